uart_tx_serializer: RTL and testbench

Downstream consumer of the AXI4-Lite UART slave's transmit byte stream (its character/write-strobe outputs). Buffers bytes in a small FIFO and serialises each one onto a single 8N1 line at a fixed clocks-per-bit rate. Returns FIFO level, full, empty and overflow status so the slave can report them in its status register.

---
 rtl/uart_tx_serializer_if.sv | 32 +++
 rtl/uart_tx_serializer.sv | 167 ++++++++++++++++
 tb/tb_uart_tx_serializer.sv | 147 ++++++++++++++
 3 files changed

// File: rtl/uart_tx_serializer_if.sv
// ============================================================================
// Module   : uart_tx_serializer_if
// Brief    : Byte-push / status bundle between the UART slave and serializer.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface uart_tx_serializer_if #(
  parameter int FIFO_AW = 3
);
  logic [7:0]       wr_char;
  logic             wr_en;
  logic             ovf_clr;
  logic             full;
  logic             tx_empty;
  logic             busy;
  logic [FIFO_AW:0] level;
  logic             overflow;
  logic             tx;

  modport master (
    output wr_char, wr_en, ovf_clr,
    input  full, tx_empty, busy, level, overflow, tx
  );

  modport slave (
    input  wr_char, wr_en, ovf_clr,
    output full, tx_empty, busy, level, overflow, tx
  );
endinterface

`default_nettype wire

// File: rtl/uart_tx_serializer.sv
// ============================================================================
// Module   : uart_tx_serializer
// Brief    : Byte FIFO feeding an 8N1 serial transmitter at DIV clocks/bit.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module uart_tx_serializer #(
  parameter int DIV     = 16,
  parameter int FIFO_AW = 3
) (
  input  logic                 clk,
  input  logic                 rst,
  uart_tx_serializer_if.slave  bus
);

  localparam int                 c_DEPTH     = 2 ** FIFO_AW;
  localparam int                 c_CW        = (DIV > 2) ? $clog2(DIV) : 1;
  localparam logic [c_CW-1:0]    c_CNT_MAX   = c_CW'(DIV - 1);
  localparam logic [c_CW-1:0]    c_CNT_ONE   = c_CW'(1);
  localparam logic [FIFO_AW-1:0] c_PTR_ONE   = FIFO_AW'(1);
  localparam logic [FIFO_AW:0]   c_LVL_ONE   = (FIFO_AW + 1)'(1);
  localparam logic [FIFO_AW:0]   c_LVL_FULL  = (FIFO_AW + 1)'(c_DEPTH);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_DATA  = 2'd2,
    S_STOP  = 2'd3
  } state_t;

  logic [7:0]         r_mem [c_DEPTH];
  logic [FIFO_AW-1:0] r_wptr;
  logic [FIFO_AW-1:0] r_rptr;
  logic [FIFO_AW:0]   r_level;
  logic               r_ovf;

  state_t             r_state;
  logic [c_CW-1:0]    r_cnt;
  logic [2:0]         r_bit;
  logic [7:0]         r_shift;
  logic               r_tx;

  logic w_full;
  logic w_empty;
  logic w_cnt_zero;
  logic w_push;
  logic w_pop;

  assign w_full     = (r_level == c_LVL_FULL);
  assign w_empty    = (r_level == '0);
  assign w_cnt_zero = (r_cnt == '0);
  assign w_push     = bus.wr_en && !w_full;
  // Pop either from idle or at the end of a stop bit, so frames chain with no gap.
  assign w_pop      = !w_empty &&
                      ((r_state == S_IDLE) || ((r_state == S_STOP) && w_cnt_zero));

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wptr] <= bus.wr_char;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_level <= '0;
      r_ovf   <= 1'b0;
    end else begin
      if (w_push) begin
        r_wptr <= r_wptr + c_PTR_ONE;
      end
      if (w_pop) begin
        r_rptr <= r_rptr + c_PTR_ONE;
      end
      case ({w_push, w_pop})
        2'b10:   r_level <= r_level + c_LVL_ONE;
        2'b01:   r_level <= r_level - c_LVL_ONE;
        default: r_level <= r_level;
      endcase
      // A dropped push wins over a same-cycle clear.
      if (bus.wr_en && w_full) begin
        r_ovf <= 1'b1;
      end else if (bus.ovf_clr) begin
        r_ovf <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_bit   <= '0;
      r_shift <= '0;
      r_tx    <= 1'b1;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_tx <= 1'b1;
          if (w_pop) begin
            r_shift <= r_mem[r_rptr];
            r_cnt   <= c_CNT_MAX;
            r_bit   <= '0;
            r_tx    <= 1'b0;
            r_state <= S_START;
          end
        end
        S_START: begin
          if (w_cnt_zero) begin
            r_cnt   <= c_CNT_MAX;
            r_tx    <= r_shift[0];
            r_state <= S_DATA;
          end else begin
            r_cnt <= r_cnt - c_CNT_ONE;
          end
        end
        S_DATA: begin
          if (w_cnt_zero) begin
            r_cnt <= c_CNT_MAX;
            if (r_bit == 3'd7) begin
              r_tx    <= 1'b1;
              r_state <= S_STOP;
            end else begin
              r_shift <= r_shift >> 1;
              r_tx    <= r_shift[1];
              r_bit   <= r_bit + 3'd1;
            end
          end else begin
            r_cnt <= r_cnt - c_CNT_ONE;
          end
        end
        S_STOP: begin
          if (w_cnt_zero) begin
            if (w_pop) begin
              r_shift <= r_mem[r_rptr];
              r_cnt   <= c_CNT_MAX;
              r_bit   <= '0;
              r_tx    <= 1'b0;
              r_state <= S_START;
            end else begin
              r_tx    <= 1'b1;
              r_state <= S_IDLE;
            end
          end else begin
            r_cnt <= r_cnt - c_CNT_ONE;
          end
        end
        default: begin
          r_tx    <= 1'b1;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.full     = w_full;
  assign bus.busy     = (r_state != S_IDLE);
  assign bus.tx_empty = w_empty && (r_state == S_IDLE);
  assign bus.level    = r_level;
  assign bus.overflow = r_ovf;
  assign bus.tx       = r_tx;

endmodule

`default_nettype wire

// File: tb/tb_uart_tx_serializer.sv
// ============================================================================
// Module   : tb_uart_tx_serializer
// Brief    : Directed + random bench against a queue/timeline model of 8N1 TX.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_uart_tx_serializer;

  localparam int DIV   = 4;
  localparam int AW    = 3;
  localparam int DEPTH = 2 ** AW;
  localparam int FRAME = 10 * DIV;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  uart_tx_serializer_if #(.FIFO_AW(AW)) bus ();

  uart_tx_serializer #(.DIV(DIV), .FIFO_AW(AW)) u_dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;

  // Model: pending bytes, plus the frame on the wire and cycles elapsed in it.
  logic [7:0] q[$];
  bit         m_act = 1'b0;
  logic [7:0] m_cur = 8'h00;
  int         m_t   = 0;
  bit         m_ovf = 1'b0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s at cycle %0d: got %0h expected %0h", tag, cyc, got, exp);
    end
  endtask

  function automatic logic exp_tx();
    int k;
    if (!m_act) return 1'b1;
    k = m_t / DIV;
    if (k == 0) return 1'b0;
    if (k >= 9) return 1'b1;
    return m_cur[k-1];
  endfunction

  task automatic model_edge(input bit r, input bit we, input logic [7:0] ch, input bit clr);
    int pre;
    if (r) begin
      q.delete();
      m_act = 1'b0;
      m_t   = 0;
      m_ovf = 1'b0;
      return;
    end
    pre = q.size();
    if (m_act) begin
      if (m_t == FRAME - 1) m_act = 1'b0;
      else                  m_t++;
    end
    if (!m_act && pre > 0) begin
      m_cur = q.pop_front();
      m_act = 1'b1;
      m_t   = 0;
    end
    if (we && pre == DEPTH) m_ovf = 1'b1;
    else if (clr)           m_ovf = 1'b0;
    if (we && pre < DEPTH) q.push_back(ch);
  endtask

  task automatic step(input bit r, input bit we, input logic [7:0] ch, input bit clr);
    @(negedge clk);
    rst         = r;
    bus.wr_en   = we;
    bus.wr_char = ch;
    bus.ovf_clr = clr;
    @(posedge clk);
    cyc++;
    model_edge(r, we, ch, clr);
    #1;
    check_eq("tx",       32'(bus.tx),       32'(exp_tx()));
    check_eq("level",    32'(bus.level),    32'(q.size()));
    check_eq("full",     32'(bus.full),     32'(q.size() == DEPTH));
    check_eq("busy",     32'(bus.busy),     32'(m_act));
    check_eq("tx_empty", 32'(bus.tx_empty), 32'(q.size() == 0 && !m_act));
    check_eq("overflow", 32'(bus.overflow), 32'(m_ovf));
  endtask

  task automatic idle(input int n);
    repeat (n) step(1'b0, 1'b0, 8'h00, 1'b0);
  endtask

  initial begin
    int prob;
    bus.wr_en   = 1'b0;
    bus.wr_char = 8'h00;
    bus.ovf_clr = 1'b0;

    // Reset held with pushes attempted: nothing may be enqueued.
    repeat (3) step(1'b1, 1'b1, 8'hC3, 1'b0);
    idle(2);

    step(1'b0, 1'b1, 8'h55, 1'b0);
    idle(FRAME + 5);

    step(1'b0, 1'b1, 8'hA5, 1'b0);
    step(1'b0, 1'b1, 8'h0F, 1'b0);
    step(1'b0, 1'b1, 8'hFF, 1'b0);
    idle(3 * FRAME + 5);

    for (int i = 0; i < 10; i++) step(1'b0, 1'b1, 8'(i), 1'b0);
    step(1'b0, 1'b1, 8'hEE, 1'b1);
    step(1'b0, 1'b0, 8'h00, 1'b1);
    idle(9 * FRAME + 5);

    // Reset lands while data bit 3 is on the line.
    step(1'b0, 1'b1, 8'h00, 1'b0);
    idle(18);
    step(1'b1, 1'b0, 8'h00, 1'b0);
    step(1'b0, 1'b1, 8'h81, 1'b0);
    idle(FRAME + 5);

    prob = 20;
    for (int i = 0; i < 3000; i++) begin
      if (i % 200 == 0) prob = int'($urandom_range(0, 100));
      step(($urandom % 600) == 0,
           int'($urandom_range(0, 99)) < prob,
           8'($urandom),
           ($urandom % 12) == 0);
    end
    idle(DEPTH * FRAME + FRAME + 5);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
